// File: rtl/boot_fetch_unit_pkg.sv
// rtl/boot_fetch_unit_pkg.sv - shared types and constants for the boot fetch stage
package boot_fetch_unit_pkg;

  localparam int          INSN_W             = 32;
  localparam logic [31:0] NOP_INSN_DEF       = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_BOOT_BYTES = 512;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  // Sequential advance keeps the carry so a wrap past 2^32 is seen as out of range.
  function automatic logic [INSN_W:0] pc_advance(input logic [INSN_W-1:0] pc);
    return {1'b0, pc} + 33'd4;
  endfunction

endpackage

// File: rtl/boot_fetch_addr_check.sv
// rtl/boot_fetch_addr_check.sv - combinational alignment and region check for boot RAM addresses
module boot_fetch_addr_check
  import boot_fetch_unit_pkg::*;
#(
  parameter int BOOT_BYTES = DEFAULT_BOOT_BYTES
) (
  input  logic [INSN_W-1:0] i_addr,
  input  logic              i_carry,
  output logic              o_misaligned,
  output logic              o_out_of_range
);

  localparam logic [INSN_W:0] LIMIT = (INSN_W + 1)'(BOOT_BYTES);

  assign o_misaligned   = (i_addr[1:0] != 2'b00);
  assign o_out_of_range = i_carry || ({1'b0, i_addr} >= LIMIT);

endmodule

// File: rtl/boot_fetch_unit.sv
// rtl/boot_fetch_unit.sv - instruction fetch from synchronous boot RAM with redirect, replay stall and sticky fault
module boot_fetch_unit
  import boot_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          BOOT_BYTES = DEFAULT_BOOT_BYTES,
  parameter logic [31:0] NOP_INSN   = NOP_INSN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect_valid,
  input  logic [INSN_W-1:0] i_redirect_pc,
  output logic [INSN_W-1:0] o_imem_addr,
  input  logic [INSN_W-1:0] i_imem_rd_data,
  output logic              o_if_valid,
  output logic [INSN_W-1:0] o_if_pc,
  output logic [INSN_W-1:0] o_if_insn,
  input  logic              i_id_ready,
  output logic              o_fault,
  output logic [INSN_W-1:0] o_fault_pc
);

  fetch_state_e      r_state;
  logic [INSN_W-1:0] r_pc_q;
  logic [INSN_W-1:0] r_fault_pc;

  logic [INSN_W:0]   w_pc_inc;
  logic [INSN_W-1:0] w_cand;
  logic              w_cand_carry;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_fault_hit;

  assign w_pc_inc = pc_advance(r_pc_q);

  // Redirect beats stall; a stall replays pc_q so the RAM output holds steady.
  always_comb begin
    w_cand       = r_pc_q;
    w_cand_carry = 1'b0;
    case (r_state)
      S_BOOT: w_cand = RESET_PC;
      S_RUN: begin
        if (i_redirect_valid) begin
          w_cand = i_redirect_pc;
        end else if (!i_id_ready) begin
          w_cand = r_pc_q;
        end else begin
          w_cand       = w_pc_inc[INSN_W-1:0];
          w_cand_carry = w_pc_inc[INSN_W];
        end
      end
      default: w_cand = r_pc_q;
    endcase
  end

  boot_fetch_addr_check #(
    .BOOT_BYTES(BOOT_BYTES)
  ) u_addr_check (
    .i_addr         (w_cand),
    .i_carry        (w_cand_carry),
    .o_misaligned   (w_misaligned),
    .o_out_of_range (w_out_of_range)
  );

  assign w_fault_hit = (r_state == S_RUN) && (w_misaligned || w_out_of_range);

  assign o_imem_addr = w_cand;
  assign o_if_valid  = (r_state == S_RUN) && !i_redirect_valid;
  assign o_if_pc     = r_pc_q;
  assign o_if_insn   = (r_state == S_RUN) ? i_imem_rd_data : NOP_INSN;
  assign o_fault     = (r_state == S_FAULT);
  assign o_fault_pc  = r_fault_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_BOOT;
      r_pc_q     <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_pc_q  <= RESET_PC;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // A faulting address is never issued as pc_q; the last good PC is kept.
          if (w_fault_hit) begin
            r_state    <= S_FAULT;
            r_fault_pc <= w_cand;
          end else begin
            r_pc_q <= w_cand;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_fetch_unit.sv
// tb/tb_boot_fetch_unit.sv - directed and randomized self-checking bench for boot_fetch_unit
module tb_boot_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam longint      REGION = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        id_ready = 1'b0;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [0:127];

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = waiting for first fetch, 1 = streaming, 2 = dead until reset
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_fault_pc;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rd_data <= mem[imem_addr[8:2]];

  boot_fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_addr      (imem_addr),
    .i_imem_rd_data   (imem_rd_data),
    .o_if_valid       (if_valid),
    .o_if_pc          (if_pc),
    .o_if_insn        (if_insn),
    .i_id_ready       (id_ready),
    .o_fault          (fault),
    .o_fault_pc       (fault_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit random_mem);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_insn", if_insn, NOP);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    if (random_mem)
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_phase    = 0;
    m_pc       = 32'd0;
    m_fault_pc = 32'd0;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    longint      a;
    logic [31:0] exp_addr;
    bit          exp_valid;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    a = 0;
    @(negedge clk);
    exp_valid = (m_phase == 1) && !rv;
    case (m_phase)
      0: a = 0;
      1: a = rv ? longint'(rpc) : (rdy ? longint'(m_pc) + 4 : longint'(m_pc));
      default: a = longint'(m_pc);
    endcase
    exp_addr = a[31:0];
    chk("imem_addr", imem_addr, exp_addr);
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    chk("fault", {31'b0, fault}, {31'b0, m_phase == 2});
    chk("fault_pc", fault_pc, m_fault_pc);
    if (m_phase == 1) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_insn", if_insn, mem[m_pc[8:2]]);
    end else begin
      chk("if_insn_nop", if_insn, NOP);
    end
    if (m_phase == 0) chk("boot_if_pc", if_pc, 32'd0);
    @(posedge clk);
    #1;
    if (m_phase == 0) begin
      m_phase = 1;
      m_pc    = 32'd0;
    end else if (m_phase == 1) begin
      if ((a % 4 == 0) && (a < REGION)) m_pc = a[31:0];
      else begin
        m_phase    = 2;
        m_fault_pc = a[31:0];
      end
    end
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    do_reset(1'b0);

    step(1'b1, 32'h100, 1'b1);         // boot cycle, redirect ignored
    step(1'b0, 32'h0, 1'b1);           // pc 0
    step(1'b0, 32'h0, 1'b1);           // pc 4
    step(1'b0, 32'h0, 1'b0);           // pc 8 stalled x3
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);           // pc 8 accepted
    chk("after_stall_pc", if_pc, 32'hC);
    step(1'b1, 32'h40, 1'b1);          // redirect at pc C
    chk("redir_target_pc", if_pc, 32'h40);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h40, 1'b0);          // redirect with stall
    chk("redir_stall_pc", if_pc, 32'h40);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h42, 1'b1);          // misaligned redirect
    chk("mis_fault_pc", fault_pc, 32'h42);
    step(1'b1, 32'h0, 1'b1);           // ignored while faulted
    step(1'b0, 32'h0, 1'b1);

    do_reset(1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h1F8, 1'b1);
    step(1'b0, 32'h0, 1'b1);           // pc 1F8
    step(1'b0, 32'h0, 1'b1);           // pc 1FC, fall-through faults
    step(1'b0, 32'h0, 1'b1);
    chk("fall_fault_pc", fault_pc, 32'h200);

    for (int round = 0; round < 5; round++) begin
      do_reset(1'b1);
      for (int c = 0; c < 120; c++) begin
        if (m_phase == 2 && $urandom_range(0, 3) == 0) break;
        r = $urandom_range(0, 99);
        case ($urandom_range(0, 9))
          0:       tgt = 32'h1F0 + {$urandom_range(0, 3), 2'b00};
          1:       tgt = {$urandom_range(0, 127), 2'b00} | 32'($urandom_range(1, 3));
          2:       tgt = 32'h200 + {$urandom_range(0, 1023), 2'b00};
          default: tgt = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
        endcase
        step(r < 12, tgt, $urandom_range(0, 9) < 7);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
